// File: rtl/prefetch_pkg.sv
// prefetch_pkg: fetch FSM state encoding and PC increment shared by the
// prefetch queue and its storage.
package prefetch_pkg;

   // IDLE: nothing outstanding, WAIT: live request, DROP: stale request
   // whose response must be thrown away.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } pq_state_t;

   // Byte distance between consecutive fetched instructions.
   localparam int unsigned PC_STEP = 32'd4;

endpackage

// File: rtl/pq_fifo.sv
// pq_fifo: ring buffer holding {pc, instruction} entries for the prefetch
// queue. Flush wins over push and pop; a pop of an empty buffer and a push
// into a full buffer (without a concurrent pop) are ignored.
module pq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   input  logic                   flush,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};
   localparam logic [PW-1:0] PTR0_C  = {PW{1'b0}};
   localparam logic [PW-1:0] PTR1_C  = PW'(1'b1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Qualify push and pop against the current occupancy
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (flush) begin
         do_push_s = 1'b0;
         do_pop_s  = 1'b0;
      end else begin
         do_pop_s  = pop && (count_r != EMPTY_C);
         do_push_s = push && ((count_r != FULL_C) || do_pop_s);
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= PTR0_C;
         rd_ptr_r <= PTR0_C;
         count_r  <= EMPTY_C;
      end else if (flush) begin
         wr_ptr_r <= PTR0_C;
         rd_ptr_r <= PTR0_C;
         count_r  <= EMPTY_C;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR1_C;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR1_C;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents need no reset because occupancy guards every read
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetcher. Keeps at most one request in
// flight to instruction memory, only when the queue is guaranteed room for
// the response, and buffers responses with their PCs for the consumer.
// A redirect flushes the queue and restarts fetching at redirect_pc; a
// response belonging to a request issued before the redirect is discarded.
// Optional build macro PREFETCH_BYPASS_EN: a response arriving while the
// queue is empty is presented to the consumer in the same cycle.
module prefetch_queue
   import prefetch_pkg::*;
#(
   parameter int            DEPTH    = 4,
   parameter int            AW       = 32,
   parameter int            IW       = 32,
   parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
   input  logic                   clk,
   input  logic                   rstd,
   output logic                   imem_req,
   output logic [AW-1:0]          imem_addr,
   input  logic                   imem_ack,
   input  logic [IW-1:0]          imem_rdata,
   output logic                   ins_valid,
   output logic [IW-1:0]          ins,
   output logic [AW-1:0]          ins_pc,
   input  logic                   ins_ready,
   input  logic                   redirect,
   input  logic [AW-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] EMPTY_C = {CW{1'b0}};
   localparam logic [AW-1:0] STEP_C  = AW'(PC_STEP);

   pq_state_t        state_r;
   pq_state_t        state_s;
   logic [AW-1:0]    fpc_r;
   logic [AW-1:0]    fpc_s;
   logic [AW-1:0]    addr_r;
   logic [AW-1:0]    addr_s;
   logic             req_r;
   logic             req_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             head_valid_s;
   logic [AW+IW-1:0] head_s;
   logic [CW-1:0]    fifo_count_s;
`ifdef PREFETCH_BYPASS_EN
   logic             bypass_s;
`endif

   // Fetch FSM: decide next state, next fetch PC and the request registers
   always_comb begin
      state_s  = state_r;
      fpc_s    = fpc_r;
      req_s    = req_r;
      addr_s   = addr_r;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // Nothing is outstanding, so a free slot is simply count < DEPTH.
            if (redirect) begin
               fpc_s = redirect_pc;
            end else if (fifo_count_s < DEPTH_C) begin
               state_s = ST_WAIT;
               req_s   = 1'b1;
               addr_s  = fpc_r;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (imem_ack) begin
               state_s = ST_IDLE;
               req_s   = 1'b0;
               if (redirect) begin
                  // Response belongs to the old path: drop it, no DROP needed.
                  fpc_s = redirect_pc;
               end else begin
                  accept_s = 1'b1;
                  fpc_s    = fpc_r + STEP_C;
               end
            end else if (redirect) begin
               // Request stays on the bus with its old address until acked.
               state_s = ST_DROP;
               fpc_s   = redirect_pc;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DROP: begin
            if (redirect) begin
               fpc_s = redirect_pc;
            end else begin
               fpc_s = fpc_r;
            end
            if (imem_ack) begin
               state_s = ST_IDLE;
               req_s   = 1'b0;
            end else begin
               state_s = ST_DROP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            req_s   = 1'b0;
         end
      endcase
   end

   // Fetch FSM state, fetch PC and request registers
   always_ff @(posedge clk or posedge rstd) begin
      if (rstd) begin
         state_r <= ST_IDLE;
         fpc_r   <= RESET_PC;
         req_r   <= 1'b0;
         addr_r  <= RESET_PC;
      end else begin
         state_r <= state_s;
         fpc_r   <= fpc_s;
         req_r   <= req_s;
         addr_r  <= addr_s;
      end
   end

   // Consumer side: head of queue (or bypassed response), pop and push control
   always_comb begin
      head_valid_s = (fifo_count_s != EMPTY_C);
      // A redirect flushes, so a same-cycle pop is meaningless.
      pop_s        = head_valid_s && ins_ready && !redirect;
`ifdef PREFETCH_BYPASS_EN
      bypass_s = accept_s && !head_valid_s;
      if (bypass_s) begin
         push_s    = !ins_ready;
         ins_valid = 1'b1;
         ins       = imem_rdata;
         ins_pc    = addr_r;
      end else begin
         push_s    = accept_s;
         ins_valid = head_valid_s;
         ins       = head_s[IW-1:0];
         ins_pc    = head_s[AW+IW-1:IW];
      end
`else
      push_s    = accept_s;
      ins_valid = head_valid_s;
      ins       = head_s[IW-1:0];
      ins_pc    = head_s[AW+IW-1:IW];
`endif
   end

   pq_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + IW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rstd),
      .push  (push_s),
      .wdata ({addr_r, imem_rdata}),
      .pop   (pop_s),
      .flush (redirect),
      .rdata (head_s),
      .count (fifo_count_s)
   );

   assign imem_req  = req_r;
   assign imem_addr = addr_r;
   assign count     = fifo_count_s;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: self-checking bench for prefetch_queue. A memory
// responder answers requests after a chosen or random latency; a queue-level
// reference model tracks which responses are kept, the expected fetch PC and
// the expected queue contents.
module tb_prefetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rstd;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic          ins_valid;
   logic [IW-1:0] ins;
   logic [AW-1:0] ins_pc;
   logic          ins_ready;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] ins;
   } entry_t;

   entry_t        mq[$];
   logic [AW-1:0] m_fpc;
   logic [AW-1:0] m_paddr;
   bit            m_pending;
   bit            m_drop;
   bit            new_req;
   bit            rand_lat;
   int            m_wait;
   int            ack_lat;

   prefetch_queue #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .IW       (IW),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rstd        (rstd),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ins_valid   (ins_valid),
      .ins         (ins),
      .ins_pc      (ins_pc),
      .ins_ready   (ins_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .count       (count)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: apply the rules for the inputs seen in the current cycle
   task automatic model_edge();
      bit     acc;
      bit     byp;
      entry_t e;
      acc = 1'b0;
      byp = 1'b0;
      if (rstd) begin
         mq.delete();
         m_fpc     = RESET_PC;
         m_pending = 1'b0;
         m_drop    = 1'b0;
         return;
      end
      if (m_pending && imem_ack) begin
         acc       = !m_drop && !redirect;
         m_pending = 1'b0;
         m_drop    = 1'b0;
      end else if (m_pending && redirect) begin
         m_drop = 1'b1;
      end
`ifdef PREFETCH_BYPASS_EN
      byp = acc && (mq.size() == 0) && ins_ready;
`endif
      if (!redirect && ins_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc && !byp) begin
         e.pc  = m_paddr;
         e.ins = imem_rdata;
         mq.push_back(e);
      end
      if (acc) m_fpc = m_paddr + 32'd4;
      if (redirect) begin
         mq.delete();
         m_fpc = redirect_pc;
      end
   endtask

   // One clock: update model, cross the edge, drive this cycle's inputs, settle
   task automatic tick(input logic rdy, input logic redir, input logic [AW-1:0] rpc);
      model_edge();
      @(posedge clk);
      #1;
      new_req = 1'b0;
      if (!m_pending && imem_req) begin
         m_pending = 1'b1;
         m_drop    = 1'b0;
         m_paddr   = imem_addr;
         m_wait    = 0;
         new_req   = 1'b1;
         if (rand_lat) ack_lat = $urandom_range(0, 2);
      end else if (m_pending) begin
         m_wait++;
      end
      ins_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      imem_rdata  = $urandom;
      imem_ack    = m_pending && imem_req && (ack_lat >= 0) && (m_wait >= ack_lat);
      @(negedge clk);
   endtask

   // Hold reset for two edges with quiet inputs and a cleared model
   task automatic apply_reset();
      rstd        = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      ins_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      mq.delete();
      m_fpc     = RESET_PC;
      m_pending = 1'b0;
      m_drop    = 1'b0;
      new_req   = 1'b0;
      rand_lat  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req actual=%0b expected=0", imem_req); end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr actual=%0h expected=%0h", imem_addr, RESET_PC); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count actual=%0d expected=0", count); end
      checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%0b expected=0", ins_valid); end
      ack_lat = -1;
      rstd = 1'b0;
      tick(1'b0, 1'b0, 32'h0);
      checks++; if (!(new_req && imem_addr === RESET_PC)) begin errors++; $display("FAIL first_req actual=%0b/%0h expected=1/%0h", imem_req, imem_addr, RESET_PC); end
      // Reset in the middle of the outstanding request, with a late ack during reset
      rstd = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin errors++; $display("FAIL midrst_req actual=%0b/%0h expected=0/%0h", imem_req, imem_addr, RESET_PC); end
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      checks++; if (count !== 3'd0 || ins_valid !== 1'b0) begin errors++; $display("FAIL midrst_ack actual=%0d/%0b expected=0/0", count, ins_valid); end
      apply_reset();
      rstd     = 1'b0;
      imem_ack = 1'b1;  // stray ack before any request: must be ignored
      tick(1'b0, 1'b0, 32'h0);
      checks++; if (!(new_req && imem_addr === RESET_PC)) begin errors++; $display("FAIL rerst_req actual=%0b/%0h expected=1/%0h", imem_req, imem_addr, RESET_PC); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL stray_ack count actual=%0d expected=0", count); end
   endtask

   task automatic test_stream();
      logic [AW-1:0] got[$];
      apply_reset();
      rstd    = 1'b0;
      ack_lat = 1;
      for (int c = 0; c < 80 && got.size() < 6; c++) begin
         tick(1'b1, 1'b0, 32'h0);
         if (ins_valid === 1'b1) got.push_back(ins_pc);
      end
      checks++; if (got.size() != 6) begin errors++; $display("FAIL stream_len actual=%0d expected=6", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== RESET_PC + 32'(4 * i)) begin
            errors++; $display("FAIL stream_pc%0d actual=%0h expected=%0h", i, got[i], RESET_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_full();
      int n;
      apply_reset();
      rstd    = 1'b0;
      ack_lat = 1;
      n = 0;
      repeat (40) begin
         tick(1'b0, 1'b0, 32'h0);
         if (new_req) n++;
      end
      checks++; if (n != DEPTH) begin errors++; $display("FAIL full_reqs actual=%0d expected=%0d", n, DEPTH); end
      checks++; if (count !== 3'(DEPTH)) begin errors++; $display("FAIL full_count actual=%0d expected=%0d", count, DEPTH); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req actual=%0b expected=0", imem_req); end
      tick(1'b1, 1'b0, 32'h0);
      n = 0;
      repeat (12) begin
         tick(1'b0, 1'b0, 32'h0);
         if (new_req) n++;
      end
      checks++; if (n != 1) begin errors++; $display("FAIL refill_reqs actual=%0d expected=1", n); end
      checks++; if (count !== 3'(DEPTH)) begin errors++; $display("FAIL refill_count actual=%0d expected=%0d", count, DEPTH); end
   endtask

   task automatic test_redirect_wait();
      bit seen_req;
      bit seen_ins;
      apply_reset();
      rstd    = 1'b0;
      ack_lat = 3;
      tick(1'b1, 1'b0, 32'h0);
      checks++; if (!new_req) begin errors++; $display("FAIL rw_issue actual=%0b expected=1", imem_req); end
      tick(1'b1, 1'b1, 32'h0000_0100);
      tick(1'b1, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rw_hold actual=%0b/%0h expected=1/%0h", imem_req, imem_addr, RESET_PC); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rw_count actual=%0d expected=0", count); end
      tick(1'b1, 1'b0, 32'h0);  // stale response arrives here
      seen_req = 1'b0;
      seen_ins = 1'b0;
      for (int c = 0; c < 30 && !(seen_req && seen_ins); c++) begin
         tick(1'b1, 1'b0, 32'h0);
         if (new_req && !seen_req) begin
            seen_req = 1'b1;
            checks++; if (imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_addr actual=%0h expected=100", imem_addr); end
         end
         if (ins_valid === 1'b1 && !seen_ins) begin
            seen_ins = 1'b1;
            checks++; if (ins_pc !== 32'h0000_0100) begin errors++; $display("FAIL rw_inspc actual=%0h expected=100", ins_pc); end
         end
      end
      checks++; if (!(seen_req && seen_ins)) begin errors++; $display("FAIL rw_timeout actual=%0b%0b expected=11", seen_req, seen_ins); end
   endtask

   task automatic test_redirect_ack();
      bit ok;
      apply_reset();
      rstd    = 1'b0;
      ack_lat = 1;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         tick(1'b0, 1'b0, 32'h0);
         ok = new_req && (mq.size() >= 2);
      end
      checks++; if (!ok) begin errors++; $display("FAIL ra_fill actual=%0d expected>=2", count); end
      tick(1'b0, 1'b1, 32'h0000_0200);  // ack and redirect in the same cycle
      tick(1'b0, 1'b0, 32'h0);
      checks++; if (count !== 3'd0 || ins_valid !== 1'b0) begin errors++; $display("FAIL ra_flush actual=%0d/%0b expected=0/0", count, ins_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_nodrop actual=%0b expected=0", imem_req); end
      tick(1'b0, 1'b0, 32'h0);
      checks++; if (!(new_req && imem_addr === 32'h0000_0200)) begin errors++; $display("FAIL ra_addr actual=%0b/%0h expected=1/200", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] got[$];
      logic [AW-1:0] exp_pc;
      apply_reset();
      rstd    = 1'b0;
      ack_lat = 1;
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 32'hFFFF_FFFC);
      for (int c = 0; c < 60 && got.size() < 3; c++) begin
         tick(1'b1, 1'b0, 32'h0);
         if (ins_valid === 1'b1) got.push_back(ins_pc);
      end
      checks++; if (got.size() != 3) begin errors++; $display("FAIL wrap_len actual=%0d expected=3", got.size()); end
      exp_pc = 32'hFFFF_FFFC;
      for (int i = 0; i < got.size(); i++) begin
         checks++; if (got[i] !== exp_pc) begin errors++; $display("FAIL wrap_pc%0d actual=%0h expected=%0h", i, got[i], exp_pc); end
         exp_pc = exp_pc + 32'd4;
      end
   endtask

`ifdef PREFETCH_BYPASS_EN
   task automatic test_bypass();
      apply_reset();
      rstd    = 1'b0;
      ack_lat = 0;
      tick(1'b1, 1'b0, 32'h0);
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (imem_ack !== 1'b1) begin errors++; $display("FAIL byp_ack actual=%0b expected=1", imem_ack); end
      checks++; if (ins_valid !== 1'b1 || ins !== 32'hDEAD_BEEF || ins_pc !== RESET_PC) begin errors++; $display("FAIL byp_ins actual=%0b/%0h/%0h expected=1/deadbeef/%0h", ins_valid, ins, ins_pc, RESET_PC); end
      ack_lat = -1;
      tick(1'b1, 1'b0, 32'h0);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_count actual=%0d expected=0", count); end
   endtask
`endif

   task automatic test_random();
      int            idle;
      bit            exp_valid;
      logic [IW-1:0] exp_ins;
      logic [AW-1:0] exp_pc;
      apply_reset();
      rstd     = 1'b0;
      rand_lat = 1'b1;
      ack_lat  = 1;
      idle     = 0;
      for (int c = 0; c < 800; c++) begin
         tick($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
         exp_valid = mq.size() > 0;
         exp_ins   = exp_valid ? mq[0].ins : 32'h0;
         exp_pc    = exp_valid ? mq[0].pc : 32'h0;
`ifdef PREFETCH_BYPASS_EN
         if (imem_ack && m_pending && !m_drop && !redirect && mq.size() == 0) begin
            exp_valid = 1'b1;
            exp_ins   = imem_rdata;
            exp_pc    = m_paddr;
         end
`endif
         checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d actual=%0d expected=%0d", c, count, mq.size()); end
         checks++; if (ins_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d actual=%0b expected=%0b", c, ins_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (ins !== exp_ins || ins_pc !== exp_pc) begin errors++; $display("FAIL rnd_head cyc=%0d actual=%0h@%0h expected=%0h@%0h", c, ins, ins_pc, exp_ins, exp_pc); end
         end
         if (new_req) begin
            checks++; if (imem_addr !== m_fpc) begin errors++; $display("FAIL rnd_addr cyc=%0d actual=%0h expected=%0h", c, imem_addr, m_fpc); end
            checks++; if (mq.size() >= DEPTH) begin errors++; $display("FAIL rnd_room cyc=%0d actual=%0d expected<%0d", c, mq.size(), DEPTH); end
         end else if (m_pending) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== m_paddr) begin errors++; $display("FAIL rnd_hold cyc=%0d actual=%0b/%0h expected=1/%0h", c, imem_req, imem_addr, m_paddr); end
         end
         if (!m_pending && mq.size() < DEPTH && !redirect) idle++;
         else idle = 0;
         checks++; if (idle > 2) begin errors++; $display("FAIL rnd_stall cyc=%0d actual=%0d expected<=2", c, idle); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
`ifdef PREFETCH_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
